rtc_rgs_mc: RTL and testbench
=============================

# rtc_rgs_mc

Parametrised successor to the RTC software register interface. It serves the 32-bit on-chip bus to the RTC, drives tick-increment, offset and clear controls to the RTC core, and adds three things: N_PTS independent PPS timestamp capture channels with sticky/overrun status and interrupt, a coherent snapshot of the 80+16-bit current time, and self-clearing control pulses of programmable width. It sits between the bus slave fabric and `rtc_core` in the PTPv2 timing subsystem.

## Interface
Parameters:
- N_PTS, 2: number of PPS timestamp channels, 1..8.
- BASE_ADDR, `RTC_BASE_ADDR`: 24-bit block base, compared against bus2ip_addr_i[31:8].
- PULSE_CYCLES, 1: width in clocks of offset_valid_o and clear_rtc_o pulses, 1..15.

Ports:
- bus2ip_clk  in  1  single clock; reset is synchronous, active-low.
- bus2ip_rst_n  in  1  synchronous active-low reset.
- bus2ip_addr_i  in  32  byte address.
- bus2ip_data_i  in  32  write data.
- bus2ip_rd_ce_i  in  1  read strobe, one cycle per access.
- bus2ip_wr_ce_i  in  1  write strobe, one cycle per access.
- ip2bus_data_o  out  32  registered read data.
- rtc_std_i  in  80  current time, {sec[47:0], ns[31:0]}.
- rtc_fns_i  in  16  current fractional ns.
- pts_std_i  in  80*N_PTS  per-channel PPS timestamp; channel c occupies [80c+79:80c].
- pts_fns_i  in  16*N_PTS  per-channel fractional ns.
- pts_vld_i  in  N_PTS  one-cycle capture strobe per channel.
- tick_inc_o  out  32  tick increment, 6.26 unsigned ns.
- ns_offset_o  out  32  ns offset.
- sc_offset_o  out  48  seconds offset.
- offset_valid_o  out  1  offset-apply pulse.
- clear_rtc_o  out  1  RTC clear pulse.
- pps_width_o  out  32  PPS output width.
- intxms_sel_o  out  1  0: 10 ms, 1: 7.8125 ms.
- irq_o  out  1  level interrupt.

## Operation
- Address map (offsets in bits [7:0]): 0x00 CTL {intxms_sel, clear_rtc busy, offset_valid busy} at [2:0]; 0x04 TICK_INC; 0x08 NS_OFST; 0x0C SC_OFST0 = sec[47:16]; 0x10 SC_OFST1 = sec[15:0]; 0x14/0x18/0x1C CUR_TM0/1/2; 0x20 PPS_W; 0x24 PTS_STAT = {overrun[N_PTS-1:0] at [23:16], new[N_PTS-1:0] at [7:0]}, write-1-to-clear; 0x28 PTS_IEN, [N_PTS-1:0]; 0x40+0x10*c+{0,4,8} channel c words 0/1/2.
- Word layout for CUR_TM and channels: word0 = std[79:48], word1 = std[47:16], word2 = {std[15:0], fns}.
- All writes take bus2ip_data_i. Accesses to unmapped offsets, channels >= N_PTS, or another base address read 0 and are ignored on write.
- CTL write: bit2 loads intxms_sel_o. Bit0=1 or bit1=1 (re)starts the respective pulse counter. Writing 0 to a pulse bit has no effect.
- Snapshot: a read of CUR_TM0 returns live rtc_std_i[79:48] and, in the same cycle, latches rtc_std_i/rtc_fns_i into a shadow. CUR_TM1/2 read from the shadow.
- Channel c: pts_vld_i[c] with new[c]=0 captures the inputs and sets new[c]. pts_vld_i[c] with new[c]=1 keeps the held data and sets overrun[c]. Reading channel words has no side effects.
- irq_o = |(new & PTS_IEN), registered.

## Timing
- Reset values: all outputs and registers are 0, including shadow, channel data, new, overrun and pulse counters.
- Read latency: ip2bus_data_o is valid in the cycle after rd_ce. It holds its value until the next read, and reads 0 after reset.
- Written outputs update in the cycle after wr_ce.
- Pulses: offset_valid_o/clear_rtc_o rise the cycle after the CTL write and stay high exactly PULSE_CYCLES cycles. A re-write while high restarts the count (pulse extends). CTL busy bits read 1 while the pulse is high.
- Capture: data and new[c] are updated the cycle after pts_vld_i[c]. irq_o follows one cycle later.
- Simultaneous W1C clear of new[c] and pts_vld_i[c]: capture wins; new[c]=1, data updated, overrun[c] unchanged. A W1C of overrun[c] with a simultaneous overrun event leaves overrun[c]=1.
- A reset asserted mid-pulse drops the pulse in the next cycle.

## Structure
- Offsets and field positions go in `ptpv2_defines.v` (PTS_STAT_ADDR, PTS_IEN_ADDR, PTS_CH_BASE, PTS_CH_STRIDE).
- Sub-module `rtc_pts_chan`: a single channel's holding register plus new/overrun logic, instantiated N_PTS times via generate.

## Test plan
- Reset, then read every mapped offset -> all return 0; irq_o=0.
- Write CTL=0x1 with PULSE_CYCLES=3 -> offset_valid_o high for exactly 3 cycles, starting 1 cycle after the write. A re-write on cycle 2 extends the pulse to 5 cycles total.
- rtc_std_i changes between CUR_TM0 and CUR_TM2 reads -> words 1/2 match the value latched at the word-0 read.
- pts_vld_i[1] with data A, then B -> channel 1 reads A; PTS_STAT=0x0002_0002. W1C 0x00020002, then vld with C -> reads C; STAT=0x2.
- PTS_IEN=0x1, pulse pts_vld_i[0] -> irq_o high 2 cycles after the strobe. A same-cycle W1C and vld keeps new[0]=1.
- Write SC_OFST0=0x12345678, SC_OFST1=0xFFFF9ABC -> sc_offset_o=0x123456789ABC.

Source files
------------

// File: rtl/rtc_rgs_mc_pkg.sv
// rtc_rgs_mc_pkg: shared constants for the RTC register slice.
// Holds the default block base address, the register offset map, the
// timestamp field widths and a helper that splits an 80+16-bit time value
// into the three 32-bit words the bus sees.
package rtc_rgs_mc_pkg;

    localparam logic [23:0] RTC_BASE_ADDR = 24'h43C000;

    localparam int STD_W = 80;  // {sec[47:0], ns[31:0]}
    localparam int FNS_W = 16;  // fractional ns

    localparam logic [7:0] CTL_ADDR      = 8'h00;
    localparam logic [7:0] TICK_INC_ADDR = 8'h04;
    localparam logic [7:0] NS_OFST_ADDR  = 8'h08;
    localparam logic [7:0] SC_OFST0_ADDR = 8'h0C;
    localparam logic [7:0] SC_OFST1_ADDR = 8'h10;
    localparam logic [7:0] CUR_TM0_ADDR  = 8'h14;
    localparam logic [7:0] CUR_TM1_ADDR  = 8'h18;
    localparam logic [7:0] CUR_TM2_ADDR  = 8'h1C;
    localparam logic [7:0] PPS_W_ADDR    = 8'h20;
    localparam logic [7:0] PTS_STAT_ADDR = 8'h24;
    localparam logic [7:0] PTS_IEN_ADDR  = 8'h28;
    localparam logic [7:0] PTS_CH_BASE   = 8'h40;
    localparam logic [7:0] PTS_CH_STRIDE = 8'h10;

    // Bit positions of the overrun/new groups inside PTS_STAT.
    localparam int PTS_OVR_LSB = 16;
    localparam int PTS_NEW_LSB = 0;

    // word0 = std[79:48], word1 = std[47:16], word2 = {std[15:0], fns}
    function automatic logic [31:0] time_word(input logic [STD_W-1:0] std,
                                              input logic [FNS_W-1:0] fns,
                                              input logic [1:0]       sel);
        logic [31:0] w;
        w = '0;
        case (sel)
            2'd0:    w = std[79:48];
            2'd1:    w = std[47:16];
            2'd2:    w = {std[15:0], fns};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rtc_rgs_mc_if.sv
// rtc_rgs_mc_if: on-chip bus slave signals for the RTC register block.
//   bus2ip_addr_i  byte address (block base in [31:8], offset in [7:0])
//   bus2ip_data_i  write data
//   bus2ip_rd_ce_i one-cycle read strobe
//   bus2ip_wr_ce_i one-cycle write strobe
//   ip2bus_data_o  registered read data, valid the cycle after rd_ce
// Handshake: each strobe is a complete single-cycle access; there is no
// ready/backpressure, the slave always accepts and answers with a fixed
// one-cycle read latency.
interface rtc_rgs_mc_if;
    logic [31:0] bus2ip_addr_i;
    logic [31:0] bus2ip_data_i;
    logic        bus2ip_rd_ce_i;
    logic        bus2ip_wr_ce_i;
    logic [31:0] ip2bus_data_o;

    modport master (
        output bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        input  ip2bus_data_o
    );

    modport slave (
        input  bus2ip_addr_i, bus2ip_data_i, bus2ip_rd_ce_i, bus2ip_wr_ce_i,
        output ip2bus_data_o
    );
endinterface

// File: rtl/rtc_pts_chan.sv
// rtc_pts_chan: one PPS timestamp capture channel.
//   clk, rst_n        clock, synchronous active-low reset
//   vld               one-cycle capture strobe
//   std_in, fns_in    timestamp presented with vld
//   clr_new, clr_ovr  write-1-to-clear requests for the status flags
//   std_q, fns_q      held timestamp
//   new_flag          a capture is held and not yet acknowledged
//   ovr_flag          a strobe arrived while new_flag was still set
module rtc_pts_chan
    import rtc_rgs_mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld,
    input  logic [STD_W-1:0] std_in,
    input  logic [FNS_W-1:0] fns_in,
    input  logic             clr_new,
    input  logic             clr_ovr,
    output logic [STD_W-1:0] std_q,
    output logic [FNS_W-1:0] fns_q,
    output logic             new_flag,
    output logic             ovr_flag
);

    // A clear of new in the same cycle as a strobe frees the slot, so the
    // strobe captures rather than counting as an overrun.
    logic capture;
    logic ovr_evt;

    assign capture = vld & (~new_flag | clr_new);
    assign ovr_evt = vld & new_flag & ~clr_new;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            std_q    <= '0;
            fns_q    <= '0;
            new_flag <= 1'b0;
            ovr_flag <= 1'b0;
        end else begin
            if (capture) begin
                std_q <= std_in;
                fns_q <= fns_in;
            end
            if (vld)
                new_flag <= 1'b1;
            else if (clr_new)
                new_flag <= 1'b0;
            // A new overrun beats a simultaneous clear.
            if (ovr_evt)
                ovr_flag <= 1'b1;
            else if (clr_ovr)
                ovr_flag <= 1'b0;
        end
    end

endmodule

// File: rtl/rtc_rgs_mc.sv
// rtc_rgs_mc: bus register interface of the RTC.
//   bus2ip_clk, bus2ip_rst_n  clock, synchronous active-low reset
//   bus                       bus slave (address/data/strobes/read data)
//   rtc_std_i, rtc_fns_i      live time from rtc_core, snapshotted on CUR_TM0 read
//   pts_std_i, pts_fns_i,
//   pts_vld_i                 per-channel PPS timestamps and capture strobes
//   tick_inc_o, ns_offset_o,
//   sc_offset_o, pps_width_o,
//   intxms_sel_o              static controls to rtc_core
//   offset_valid_o,
//   clear_rtc_o               self-clearing pulses, PULSE_CYCLES wide
//   irq_o                     level interrupt: any enabled channel has new data
module rtc_rgs_mc
    import rtc_rgs_mc_pkg::*;
#(
    parameter int          N_PTS        = 2,
    parameter logic [23:0] BASE_ADDR    = RTC_BASE_ADDR,
    parameter int          PULSE_CYCLES = 1
) (
    input  logic                     bus2ip_clk,
    input  logic                     bus2ip_rst_n,
    rtc_rgs_mc_if.slave              bus,
    input  logic [STD_W-1:0]         rtc_std_i,
    input  logic [FNS_W-1:0]         rtc_fns_i,
    input  logic [STD_W*N_PTS-1:0]   pts_std_i,
    input  logic [FNS_W*N_PTS-1:0]   pts_fns_i,
    input  logic [N_PTS-1:0]         pts_vld_i,
    output logic [31:0]              tick_inc_o,
    output logic [31:0]              ns_offset_o,
    output logic [47:0]              sc_offset_o,
    output logic                     offset_valid_o,
    output logic                     clear_rtc_o,
    output logic [31:0]              pps_width_o,
    output logic                     intxms_sel_o,
    output logic                     irq_o
);

    logic [7:0]       ofs;
    logic             hit;
    logic             wr;
    logic             rd;
    logic [7:0]       ch_rel;
    logic [3:0]       ch_idx;
    logic             ch_word_ok;

    logic [3:0]       ofs_cnt;
    logic [3:0]       clr_cnt;
    logic [STD_W-1:0] shadow_std;
    logic [FNS_W-1:0] shadow_fns;
    logic [N_PTS-1:0] ien;
    logic [N_PTS-1:0] new_vec;
    logic [N_PTS-1:0] ovr_vec;
    logic [N_PTS-1:0] clr_new;
    logic [N_PTS-1:0] clr_ovr;
    logic [STD_W-1:0] ch_std [N_PTS];
    logic [FNS_W-1:0] ch_fns [N_PTS];
    logic [31:0]      rd_data;

    assign ofs = bus.bus2ip_addr_i[7:0];
    assign hit = (bus.bus2ip_addr_i[31:8] == BASE_ADDR);
    assign wr  = hit & bus.bus2ip_wr_ce_i;
    assign rd  = hit & bus.bus2ip_rd_ce_i;

    // Channel window: 16-byte stride above PTS_CH_BASE, words at +0/+4/+8.
    assign ch_rel     = ofs - PTS_CH_BASE;
    assign ch_idx     = ch_rel[7:4];
    assign ch_word_ok = (ofs >= PTS_CH_BASE) && (ch_rel[1:0] == 2'b00) &&
                        (ch_rel[3:2] != 2'b11);

    assign offset_valid_o = (ofs_cnt != 4'd0);
    assign clear_rtc_o    = (clr_cnt != 4'd0);

    assign clr_new = (wr && ofs == PTS_STAT_ADDR) ?
                     bus.bus2ip_data_i[PTS_NEW_LSB +: N_PTS] : '0;
    assign clr_ovr = (wr && ofs == PTS_STAT_ADDR) ?
                     bus.bus2ip_data_i[PTS_OVR_LSB +: N_PTS] : '0;

    for (genvar g = 0; g < N_PTS; g++) begin : g_chan
        rtc_pts_chan u_chan (
            .clk      (bus2ip_clk),
            .rst_n    (bus2ip_rst_n),
            .vld      (pts_vld_i[g]),
            .std_in   (pts_std_i[STD_W*g +: STD_W]),
            .fns_in   (pts_fns_i[FNS_W*g +: FNS_W]),
            .clr_new  (clr_new[g]),
            .clr_ovr  (clr_ovr[g]),
            .std_q    (ch_std[g]),
            .fns_q    (ch_fns[g]),
            .new_flag (new_vec[g]),
            .ovr_flag (ovr_vec[g])
        );
    end

    always_comb begin
        rd_data = '0;
        case (ofs)
            CTL_ADDR:      rd_data = {29'd0, intxms_sel_o, clear_rtc_o, offset_valid_o};
            TICK_INC_ADDR: rd_data = tick_inc_o;
            NS_OFST_ADDR:  rd_data = ns_offset_o;
            SC_OFST0_ADDR: rd_data = sc_offset_o[47:16];
            SC_OFST1_ADDR: rd_data = {16'd0, sc_offset_o[15:0]};
            CUR_TM0_ADDR:  rd_data = rtc_std_i[79:48];
            CUR_TM1_ADDR:  rd_data = time_word(shadow_std, shadow_fns, 2'd1);
            CUR_TM2_ADDR:  rd_data = time_word(shadow_std, shadow_fns, 2'd2);
            PPS_W_ADDR:    rd_data = pps_width_o;
            PTS_STAT_ADDR: rd_data = (32'(ovr_vec) << PTS_OVR_LSB) |
                                     (32'(new_vec) << PTS_NEW_LSB);
            PTS_IEN_ADDR:  rd_data = 32'(ien);
            default: begin
                for (int c = 0; c < N_PTS; c++) begin
                    if (ch_word_ok && ch_idx == 4'(c))
                        rd_data = time_word(ch_std[c], ch_fns[c], ch_rel[3:2]);
                end
            end
        endcase
    end

    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            tick_inc_o    <= '0;
            ns_offset_o   <= '0;
            sc_offset_o   <= '0;
            pps_width_o   <= '0;
            intxms_sel_o  <= 1'b0;
            ien           <= '0;
            shadow_std    <= '0;
            shadow_fns    <= '0;
            bus.ip2bus_data_o <= '0;
            irq_o         <= 1'b0;
        end else begin
            if (wr) begin
                case (ofs)
                    CTL_ADDR:      intxms_sel_o        <= bus.bus2ip_data_i[2];
                    TICK_INC_ADDR: tick_inc_o          <= bus.bus2ip_data_i;
                    NS_OFST_ADDR:  ns_offset_o         <= bus.bus2ip_data_i;
                    SC_OFST0_ADDR: sc_offset_o[47:16]  <= bus.bus2ip_data_i;
                    SC_OFST1_ADDR: sc_offset_o[15:0]   <= bus.bus2ip_data_i[15:0];
                    PPS_W_ADDR:    pps_width_o         <= bus.bus2ip_data_i;
                    PTS_IEN_ADDR:  ien                 <= bus.bus2ip_data_i[N_PTS-1:0];
                    default: ;
                endcase
            end
            // Reading the top word freezes the rest of the time value so the
            // following word reads are coherent with it.
            if (rd && ofs == CUR_TM0_ADDR) begin
                shadow_std <= rtc_std_i;
                shadow_fns <= rtc_fns_i;
            end
            if (bus.bus2ip_rd_ce_i)
                bus.ip2bus_data_o <= hit ? rd_data : 32'd0;
            irq_o <= |(new_vec & ien);
        end
    end

    // Pulse counters: loading while non-zero restarts the count, which is
    // how a re-write stretches an active pulse.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            ofs_cnt <= '0;
            clr_cnt <= '0;
        end else begin
            if (wr && ofs == CTL_ADDR && bus.bus2ip_data_i[0])
                ofs_cnt <= 4'(PULSE_CYCLES);
            else if (ofs_cnt != 4'd0)
                ofs_cnt <= ofs_cnt - 4'd1;
            if (wr && ofs == CTL_ADDR && bus.bus2ip_data_i[1])
                clr_cnt <= 4'(PULSE_CYCLES);
            else if (clr_cnt != 4'd0)
                clr_cnt <= clr_cnt - 4'd1;
        end
    end

endmodule

// File: tb/tb_rtc_rgs_mc.sv
module tb_rtc_rgs_mc;
    import rtc_rgs_mc_pkg::*;

    localparam int          N_PTS = 2;
    localparam int          PULSE = 3;
    localparam logic [23:0] BASE  = 24'h43C000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rtc_rgs_mc_if bus_if();

    logic [79:0]         rtc_std;
    logic [15:0]         rtc_fns;
    logic [80*N_PTS-1:0] pts_std;
    logic [16*N_PTS-1:0] pts_fns;
    logic [N_PTS-1:0]    pts_vld;
    logic [31:0]         tick_inc, ns_offset, pps_width;
    logic [47:0]         sc_offset;
    logic                offset_valid, clear_rtc, intxms_sel, irq;

    rtc_rgs_mc #(.N_PTS(N_PTS), .BASE_ADDR(BASE), .PULSE_CYCLES(PULSE)) dut (
        .bus2ip_clk     (clk),
        .bus2ip_rst_n   (rst_n),
        .bus            (bus_if.slave),
        .rtc_std_i      (rtc_std),
        .rtc_fns_i      (rtc_fns),
        .pts_std_i      (pts_std),
        .pts_fns_i      (pts_fns),
        .pts_vld_i      (pts_vld),
        .tick_inc_o     (tick_inc),
        .ns_offset_o    (ns_offset),
        .sc_offset_o    (sc_offset),
        .offset_valid_o (offset_valid),
        .clear_rtc_o    (clear_rtc),
        .pps_width_o    (pps_width),
        .intxms_sel_o   (intxms_sel),
        .irq_o          (irq)
    );

    // ---------------- scoreboard ----------------
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a(input logic [7:0] o);
        return {BASE, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_if.bus2ip_addr_i  = addr;
        bus_if.bus2ip_data_i  = data;
        bus_if.bus2ip_wr_ce_i = 1'b1;
        @(negedge clk);
        bus_if.bus2ip_wr_ce_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus_if.bus2ip_addr_i  = addr;
        bus_if.bus2ip_rd_ce_i = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        bus_if.bus2ip_rd_ce_i = 1'b0;
        chk(name_q.pop_front(), {32'd0, bus_if.ip2bus_data_o}, {32'd0, exp_q.pop_front()});
    endtask

    task automatic pts_strobe(input int c, input logic [79:0] s, input logic [15:0] f);
        @(negedge clk);
        pts_std[80*c +: 80] = s;
        pts_fns[16*c +: 16] = f;
        pts_vld[c] = 1'b1;
        @(negedge clk);
        pts_vld = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] addr;
        bit          do_wr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vec_q[$];

    task automatic add_vec(input logic [31:0] addr, input bit do_wr, input logic [31:0] wdata,
                           input logic [31:0] exp, input string name);
        vec_t v;
        v.addr = addr; v.do_wr = do_wr; v.wdata = wdata; v.exp = exp; v.name = name;
        vec_q.push_back(v);
    endtask

    logic [7:0] rst_ofs [17] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                                8'h20, 8'h24, 8'h28, 8'h40, 8'h44, 8'h48, 8'h50, 8'h54, 8'h58};

    initial begin
        int hi;
        bus_if.bus2ip_addr_i  = '0;
        bus_if.bus2ip_data_i  = '0;
        bus_if.bus2ip_rd_ce_i = 1'b0;
        bus_if.bus2ip_wr_ce_i = 1'b0;
        rtc_std = '0; rtc_fns = '0;
        pts_std = '0; pts_fns = '0; pts_vld = '0;

        for (int i = 0; i < 17; i++) add_vec(a(rst_ofs[i]), 1'b0, 32'd0, 32'd0, "reset_rd");
        add_vec(a(8'h04), 1'b1, 32'h0A00_0001, 32'h0A00_0001, "tick_inc");
        add_vec(a(8'h08), 1'b1, 32'h3B9A_C9FF, 32'h3B9A_C9FF, "ns_ofst");
        add_vec(a(8'h0C), 1'b1, 32'h1234_5678, 32'h1234_5678, "sc_ofst0");
        add_vec(a(8'h10), 1'b1, 32'hFFFF_9ABC, 32'h0000_9ABC, "sc_ofst1");
        add_vec(a(8'h20), 1'b1, 32'h00BE_BC20, 32'h00BE_BC20, "pps_w");
        add_vec(a(8'h00), 1'b1, 32'h0000_0004, 32'h0000_0004, "ctl_intxms");
        add_vec(a(8'h28), 1'b1, 32'h0000_00FF, 32'h0000_0003, "ien_mask");
        add_vec(a(8'h28), 1'b1, 32'h0000_0000, 32'h0000_0000, "ien_zero");
        add_vec(a(8'h2C), 1'b1, 32'hDEAD_BEEF, 32'h0000_0000, "unmapped");
        add_vec(a(8'h60), 1'b1, 32'h0000_0001, 32'h0000_0000, "chan_beyond");
        add_vec(a(8'h4C), 1'b1, 32'h0000_0001, 32'h0000_0000, "chan_word3");
        add_vec({BASE + 24'd1, 8'h04}, 1'b1, 32'h0000_0055, 32'h0000_0000, "other_base");

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_irq", {63'd0, irq}, 64'd0);
        chk("reset_rdata", {32'd0, bus_if.ip2bus_data_o}, 64'd0);

        foreach (vec_q[i]) begin
            if (vec_q[i].do_wr) bus_write(vec_q[i].addr, vec_q[i].wdata);
            bus_read(vec_q[i].addr, vec_q[i].exp, vec_q[i].name);
        end
        chk("tick_inc_o", {32'd0, tick_inc}, 64'h0A00_0001);
        chk("ns_offset_o", {32'd0, ns_offset}, 64'h3B9A_C9FF);
        chk("sc_offset_o", {16'd0, sc_offset}, 64'h1234_5678_9ABC);
        chk("pps_width_o", {32'd0, pps_width}, 64'h00BE_BC20);
        chk("intxms_sel_o", {63'd0, intxms_sel}, 64'd1);

        // Coherent snapshot
        rtc_std = 80'h1111_2222_3333_4444_5555; rtc_fns = 16'hABCD;
        bus_read(a(8'h14), 32'h1111_2222, "cur_tm0");
        rtc_std = 80'h9999_8888_7777_6666_0000; rtc_fns = 16'h1234;
        bus_read(a(8'h18), 32'h3333_4444, "cur_tm1_shadow");
        bus_read(a(8'h1C), 32'h5555_ABCD, "cur_tm2_shadow");
        bus_read(a(8'h14), 32'h9999_8888, "cur_tm0_live");

        // Channel 1 capture / overrun / W1C
        pts_strobe(1, 80'hA0A1_A2A3_A4A5_A6A7_A8A9, 16'hAAAA);
        pts_strobe(1, 80'hB0B1_B2B3_B4B5_B6B7_B8B9, 16'hBBBB);
        bus_read(a(8'h50), 32'hA0A1_A2A3, "ch1_w0_held");
        bus_read(a(8'h54), 32'hA4A5_A6A7, "ch1_w1_held");
        bus_read(a(8'h58), 32'hA8A9_AAAA, "ch1_w2_held");
        bus_read(a(8'h24), 32'h0002_0002, "stat_overrun");
        chk("irq_masked", {63'd0, irq}, 64'd0);
        bus_write(a(8'h24), 32'h0002_0002);
        bus_read(a(8'h24), 32'h0000_0000, "stat_w1c");
        pts_strobe(1, 80'hC0C1_C2C3_C4C5_C6C7_C8C9, 16'hCCCC);
        bus_read(a(8'h50), 32'hC0C1_C2C3, "ch1_w0_new");
        bus_read(a(8'h58), 32'hC8C9_CCCC, "ch1_w2_new");
        bus_read(a(8'h24), 32'h0000_0002, "stat_new1");

        // Interrupt latency on channel 0
        bus_write(a(8'h28), 32'h0000_0001);
        @(negedge clk);
        pts_std[79:0] = 80'hE0E1_E2E3_E4E5_E6E7_E8E9; pts_fns[15:0] = 16'hEEEE;
        pts_vld = 2'b01;
        @(negedge clk);
        pts_vld = '0;
        chk("irq_lat1", {63'd0, irq}, 64'd0);
        @(negedge clk);
        chk("irq_lat2", {63'd0, irq}, 64'd1);

        // Same-cycle W1C of new[0] and a strobe: capture wins
        @(negedge clk);
        bus_if.bus2ip_addr_i = a(8'h24); bus_if.bus2ip_data_i = 32'h0000_0001;
        bus_if.bus2ip_wr_ce_i = 1'b1;
        pts_std[79:0] = 80'hD0D1_D2D3_D4D5_D6D7_D8D9; pts_fns[15:0] = 16'hDDDD;
        pts_vld = 2'b01;
        @(negedge clk);
        bus_if.bus2ip_wr_ce_i = 1'b0; pts_vld = '0;
        bus_read(a(8'h24), 32'h0000_0003, "stat_w1c_race");
        bus_read(a(8'h40), 32'hD0D1_D2D3, "ch0_race_w0");
        bus_read(a(8'h48), 32'hD8D9_DDDD, "ch0_race_w2");
        chk("irq_held", {63'd0, irq}, 64'd1);

        // Overrun W1C racing a fresh overrun keeps overrun set
        pts_strobe(1, 80'hF0F1_F2F3_F4F5_F6F7_F8F9, 16'hFFFF);
        bus_read(a(8'h24), 32'h0002_0003, "stat_ovr1");
        bus_read(a(8'h50), 32'hC0C1_C2C3, "ch1_kept");
        @(negedge clk);
        bus_if.bus2ip_addr_i = a(8'h24); bus_if.bus2ip_data_i = 32'h0002_0000;
        bus_if.bus2ip_wr_ce_i = 1'b1;
        pts_vld = 2'b10;
        @(negedge clk);
        bus_if.bus2ip_wr_ce_i = 1'b0; pts_vld = '0;
        bus_read(a(8'h24), 32'h0002_0003, "stat_ovr_race");
        bus_write(a(8'h24), 32'h0002_0000);
        bus_read(a(8'h24), 32'h0000_0003, "stat_ovr_clr");

        // Single pulse: exactly PULSE cycles, starting the cycle after the write
        bus_write(a(8'h00), 32'h0000_0005);
        for (int i = 0; i < 6; i++) begin
            chk("pulse_single", {63'd0, offset_valid}, {63'd0, (i < PULSE)});
            @(negedge clk);
        end

        // Re-write during the second high cycle stretches to 5 cycles
        bus_write(a(8'h00), 32'h0000_0005);
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (offset_valid) hi++;
            if (i == 1) begin
                bus_if.bus2ip_addr_i = a(8'h00); bus_if.bus2ip_data_i = 32'h0000_0005;
                bus_if.bus2ip_wr_ce_i = 1'b1;
            end else if (i == 2) begin
                bus_if.bus2ip_wr_ce_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("pulse_extend", 64'(hi), 64'd5);
        chk("pulse_extend_end", {63'd0, offset_valid}, 64'd0);

        // Busy bit visible while clear pulse is high
        bus_write(a(8'h00), 32'h0000_0006);
        bus_read(a(8'h00), 32'h0000_0006, "ctl_busy");
        repeat (3) @(negedge clk);
        bus_read(a(8'h00), 32'h0000_0004, "ctl_idle");

        // Reset in the middle of a pulse
        bus_write(a(8'h00), 32'h0000_0006);
        chk("clear_rtc_high", {63'd0, clear_rtc}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("clear_rtc_rst", {63'd0, clear_rtc}, 64'd0);
        chk("rst_tick_inc", {32'd0, tick_inc}, 64'd0);
        chk("rst_intxms", {63'd0, intxms_sel}, 64'd0);
        chk("rst_irq", {63'd0, irq}, 64'd0);
        chk("rst_rdata", {32'd0, bus_if.ip2bus_data_o}, 64'd0);
        rst_n = 1'b1;
        bus_read(a(8'h24), 32'h0000_0000, "rst_stat");
        bus_read(a(8'h40), 32'h0000_0000, "rst_ch0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
